// File: rtl/jpeg_pkg.sv
// Shared constants, FSM state type and bit-alignment helpers for the JPEG bitstream packer.
// Optional byte stuffing is selected with the JPEG_BYTE_STUFF_EN macro.
package jpeg_pkg;

  localparam int         BUF_W_DEFAULT    = 32;
  localparam int         MAX_CODE_BITS    = 16;
  localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;
  localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } jpeg_state_e;

  function automatic logic [4:0] clamp_bits(input logic [4:0] bits);
    return (bits > 5'(MAX_CODE_BITS)) ? 5'(MAX_CODE_BITS) : bits;
  endfunction

  // Left-align the masked code word, then slide it down behind the bits already held.
  function automatic logic [31:0] align_code(input logic [15:0] data, input logic [4:0] bits,
                                             input logic [5:0] fill);
    logic [31:0] mask;
    logic [31:0] left;
    mask = (32'h0000_0001 << bits) - 32'h0000_0001;
    left = ({16'h0000, data} & mask) << (6'd32 - {1'b0, bits});
    return left >> fill;
  endfunction

  function automatic logic [31:0] pad_ones(input logic [5:0] fill, input logic [5:0] fill_pad);
    return (32'hFFFF_FFFF >> fill) & ~(32'hFFFF_FFFF >> fill_pad);
  endfunction

endpackage

// File: rtl/jpeg_bitstream_packer_stuffer.sv
// Single-entry output byte register; inserts 0x00 after every emitted 0xFF when
// JPEG_BYTE_STUFF_EN is defined, otherwise passes bytes through unmodified.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       stuff_pending
);

  logic       valid_r;
  logic [7:0] data_r;
  logic       fire_s;
  logic       need_stuff_s;

  assign fire_s = valid_r && out_ready;

`ifdef JPEG_BYTE_STUFF_EN
  logic pending_r;

  assign need_stuff_s  = fire_s && (data_r == JPEG_MARKER_BYTE);
  assign stuff_pending = pending_r;

  // Marks that the output register currently holds an inserted stuff byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= need_stuff_s || (pending_r && !fire_s);
    end
  end
`else
  assign need_stuff_s  = 1'b0;
  assign stuff_pending = 1'b0;
`endif

  // A stuff byte always wins over new accumulator data.
  assign in_ready  = (!valid_r || fire_s) && !need_stuff_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Output byte register: load stuff, load new data, or empty on transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else if (need_stuff_s) begin
      valid_r <= 1'b1;
      data_r  <= JPEG_STUFF_BYTE;
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (fire_s) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// JPEG entropy-coded bit packer: MSB-first accumulator, 1-bit pad on flush, byte output.
// Byte stuffing after 0xFF is enabled by defining JPEG_BYTE_STUFF_EN.
module jpeg_bitstream_packer
  import jpeg_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [15:0] code_data,
  input  logic [4:0]  code_bits,
  input  logic        flush_req,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        flush_done,
  output logic        busy
);

  jpeg_state_e      state_r, state_s;
  logic [BUF_W-1:0] acc_r, acc_s, merged_acc_s;
  logic [5:0]       fill_r, fill_s, merged_fill_s, pad_fill_s;
  logic [4:0]       bits_s;
  logic             ready_r;
  logic             code_fire_s;
  logic             in_valid_s, in_ready_s, pop_s;
  logic             stuff_pending_s;

  assign bits_s      = clamp_bits(code_bits);
  assign code_fire_s = code_valid && ready_r;
  assign pad_fill_s  = {fill_r[5:3] + {2'b00, |fill_r[2:0]}, 3'b000};

  // Merge the incoming code (or flush padding) and pop the oldest byte in the same cycle.
  always_comb begin
    merged_acc_s  = acc_r;
    merged_fill_s = fill_r;
    if (code_fire_s) begin
      merged_acc_s  = acc_r | align_code(code_data, bits_s, fill_r);
      merged_fill_s = fill_r + {1'b0, bits_s};
    end else if (state_r == PAD) begin
      merged_acc_s  = acc_r | pad_ones(fill_r, pad_fill_s);
      merged_fill_s = pad_fill_s;
    end else begin
      merged_acc_s  = acc_r;
      merged_fill_s = fill_r;
    end
    in_valid_s = (merged_fill_s >= 6'd8);
    pop_s      = in_valid_s && in_ready_s;
    if (pop_s) begin
      acc_s  = merged_acc_s << 4'd8;
      fill_s = merged_fill_s - 6'd8;
    end else begin
      acc_s  = merged_acc_s;
      fill_s = merged_fill_s;
    end
  end

  // Flush sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN:     if (flush_req) state_s = PAD; else state_s = RUN;
      PAD:     state_s = DRAIN;
      DRAIN:   if ((fill_r == 6'd0) && !byte_valid && !stuff_pending_s) state_s = DONE;
               else state_s = DRAIN;
      DONE:    state_s = RUN;
      default: state_s = RUN;
    endcase
  end

  // State, accumulator and the registered code_ready derived from next-state values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RUN;
      acc_r   <= {BUF_W{1'b0}};
      fill_r  <= 6'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      fill_r  <= fill_s;
      ready_r <= (state_s == RUN) && (fill_s <= 6'd16);
    end
  end

  jpeg_byte_stuffer u_stuffer (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid_s),
    .in_data       (merged_acc_s[BUF_W-1 -: 8]),
    .in_ready      (in_ready_s),
    .out_valid     (byte_valid),
    .out_data      (byte_data),
    .out_ready     (byte_ready),
    .stuff_pending (stuff_pending_s)
  );

  assign code_ready = ready_r;
  assign flush_done = (state_r == DONE);
  assign busy       = (fill_r != 6'd0) || byte_valid || stuff_pending_s || (state_r != RUN);

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Directed self-checking bench for jpeg_bitstream_packer; expectations follow JPEG_BYTE_STUFF_EN.
module tb_jpeg_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_data;
  logic [4:0]  code_bits;
  logic        flush_req;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        flush_done;
  logic        busy;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         model_q[$];

  always #5 clock = ~clock;

  jpeg_bitstream_packer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .code_bits  (code_bits),
    .flush_req  (flush_req),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always @(posedge clock) begin
    if (reset_n && byte_valid && byte_ready) got_q.push_back(byte_data);
    if (flush_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) byte_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_code(input logic [15:0] d, input logic [4:0] b);
    int n;
    int eb;
    code_data  = d;
    code_bits  = b;
    code_valid = 1'b1;
    n = 0;
    while (!code_ready && n < 200) begin
      tick();
      n++;
    end
    check("code_accept", 32'(code_ready), 32'd1);
    tick();
    code_valid = 1'b0;
    eb = (int'(b) > 16) ? 16 : int'(b);
    for (int i = eb - 1; i >= 0; i--) model_q.push_back(d[i]);
  endtask

  task automatic do_flush(input string tag);
    int n;
    int d0;
    d0 = done_cnt;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_flush_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic model_bytes();
    logic [7:0] b;
    while (model_q.size() % 8 != 0) model_q.push_back(1'b1);
    while (model_q.size() > 0) begin
      for (int k = 7; k >= 0; k--) b[k] = model_q.pop_front();
      exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
      if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    model_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; code_valid = 1'b0; code_data = 16'h0000; code_bits = 5'd0;
    flush_req = 1'b0; byte_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'h00);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(code_ready), 32'd1);

    // Empty flush: flush_done two edges after the request edge, no bytes.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("empty_pad_done", 32'(flush_done), 32'd0);
    check("empty_pad_busy", 32'(busy), 32'd1);
    tick();
    check("empty_drain_done", 32'(flush_done), 32'd0);
    tick();
    check("empty_done_pulse", 32'(flush_done), 32'd1);
    tick();
    check("empty_done_low", 32'(flush_done), 32'd0);
    check("empty_ready_back", 32'(code_ready), 32'd1);
    check_stream("empty");

    // Scenario 1: 101 + 11111 -> 0xBF, visible the cycle after acceptance.
    send_code(16'h0005, 5'd3);
    send_code(16'h001F, 5'd5);
    check("s1_latency_valid", 32'(byte_valid), 32'd1);
    check("s1_latency_data", 32'(byte_data), 32'hBF);
    do_flush("s1");
    exp_q = '{8'hBF};
    check_stream("s1");

    // Scenario 2: 0xFFFF x16.
    send_code(16'hFFFF, 5'd16);
    do_flush("s2");
`ifdef JPEG_BYTE_STUFF_EN
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'h00};
`else
    exp_q = '{8'hFF, 8'hFF};
`endif
    check_stream("s2");

    // Scenario 3: 1-bit codes padded with ones.
    send_code(16'h0000, 5'd1);
    do_flush("s3a");
    exp_q = '{8'h7F};
    check_stream("s3a");
    send_code(16'h0001, 5'd1);
    do_flush("s3b");
`ifdef JPEG_BYTE_STUFF_EN
    exp_q = '{8'hFF, 8'h00};
`else
    exp_q = '{8'hFF};
`endif
    check_stream("s3b");

    // Masking of upper bits, zero-length no-op and length saturation.
    send_code(16'hFFF5, 5'd4);
    send_code(16'hFFFF, 5'd0);
    send_code(16'hABC3, 5'd4);
    send_code(16'h0F0F, 5'd20);
    do_flush("mask");
    exp_q = '{8'h53, 8'h0F, 8'h0F};
    check_stream("mask");

    // Scenario 4: backpressure.
    byte_ready = 1'b0;
    send_code(16'hAAAA, 5'd16);
    send_code(16'hAAAA, 5'd16);
    check("s4_ready_low", 32'(code_ready), 32'd0);
    check("s4_valid", 32'(byte_valid), 32'd1);
    check("s4_data", 32'(byte_data), 32'hAA);
    repeat (5) tick();
    check("s4_data_hold", 32'(byte_data), 32'hAA);
    check("s4_ready_hold", 32'(code_ready), 32'd0);
    check("s4_none_taken", 32'(got_q.size()), 32'd0);
    byte_ready = 1'b1;
    send_code(16'hAAAA, 5'd16);
    send_code(16'hAAAA, 5'd16);
    do_flush("s4");
    exp_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    check_stream("s4");

    // Scenario 5: reset discards 11 buffered bits.
    byte_ready = 1'b0;
    send_code(16'h05A5, 5'd11);
    tick();
    reset_n = 1'b0;
    #1;
    check("s5_valid", 32'(byte_valid), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_data", 32'(byte_data), 32'h00);
    check("s5_ready", 32'(code_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    byte_ready = 1'b1;
    check("s5_busy_after", 32'(busy), 32'd0);
    do_flush("s5");
    exp_q.delete();
    check_stream("s5");

    // Scenario 6: random lengths and handshakes against the bit-queue model.
    rnd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 40; c++) begin
        send_code(16'($urandom), 5'($urandom_range(0, 16)));
        repeat ($urandom_range(0, 2)) tick();
      end
      do_flush($sformatf("rnd%0d", r));
      model_bytes();
      check_stream($sformatf("rnd%0d", r));
    end
    rnd_ready = 1'b0;
    byte_ready = 1'b1;
    tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_packer.md
JPEG_BITSTREAM_PACKER -- requirements
Module: jpeg_bitstream_packer

Interface
REQ-001 Parameter BUF_W, default 32: bit-accumulator width in bits; only the value 32 is supported.
REQ-002 clock  in  1  single clock for the block; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 code_valid  in  1  a variable-length code word is offered on code_data/code_bits.
REQ-005 code_ready  out  1  the block accepts the offered code word in the current cycle.
REQ-006 code_data  in  16  code word, right-aligned; only bits [code_bits-1:0] are used.
REQ-007 code_bits  in  5  code length, 0..16.
REQ-008 flush_req  in  1  single-cycle pulse requesting end-of-scan pad and drain.
REQ-009 byte_valid  out  1  byte_data holds a valid output byte.
REQ-010 byte_ready  in  1  the downstream consumer accepts the byte.
REQ-011 byte_data  out  8  packed, byte-stuffed JPEG entropy-coded byte.
REQ-012 flush_done  out  1  single-cycle pulse when flush completes and the buffer is empty.
REQ-013 busy  out  1  high when the buffer is not empty, a stuff byte is pending, or a flush is in progress.

Function
REQ-014 The accumulator shall append bits MSB-first: code_data[code_bits-1] is inserted first; bits above code_bits are masked to 0.
REQ-015 A code word transfers when code_valid && code_ready; code_bits=0 is accepted as a no-op, and code_bits>16 is treated as 16.
REQ-016 code_ready shall be (fill_count <= 16) && state==RUN, computed from registered state only, with no combinational path from code_valid.
REQ-017 Whenever fill_count >= 8 and no stuff byte is pending, the output byte shall be the oldest 8 bits in the accumulator.
REQ-018 A byte transfers when byte_valid && byte_ready; byte_valid/byte_data shall hold stable until the byte is taken.
REQ-019 In the same cycle, a code accept and a byte emit may both occur; the new fill_count is old + bits - 8.
REQ-020 After a 0xFF byte transfers, the next byte shall be 0x00 (stuff_pending), taking priority over accumulator data.
REQ-021 Latency: a code word that completes a byte shall have that byte visible on byte_valid the following cycle.
REQ-022 The FSM states shall be RUN, PAD, DRAIN and DONE.
REQ-023 RUN: on flush_req, go to PAD; while flush_req is pending, no new code is accepted after that cycle.
REQ-024 PAD: if fill_count mod 8 != 0, append 1-bits to the next byte boundary in one cycle; then go to DRAIN.
REQ-025 DRAIN: emit the remaining bytes, including a stuff byte if pending; when fill_count==0 and nothing is pending, go to DONE.
REQ-026 DONE: assert flush_done for one cycle, then return to RUN.
REQ-027 flush_req with an empty buffer shall reach DONE with zero bytes emitted and pulse flush_done two cycles after the request.
REQ-028 flush_req received outside RUN shall be ignored.

Reset
REQ-029 On reset_n low, outputs shall reset to: code_ready=0, byte_valid=0, byte_data=0x00, flush_done=0, busy=0; fill_count=0, stuff_pending=0, state=RUN.
REQ-030 Reset asserted mid-operation shall discard all buffered bits and any pending stuff byte, with no partial byte emitted.
REQ-031 code_ready shall rise in the first cycle after reset deasserts.

Configuration
REQ-032 Macro JPEG_BYTE_STUFF_EN: when defined, 0x00 shall be inserted after every emitted 0xFF (REQ-020).
REQ-033 When JPEG_BYTE_STUFF_EN is undefined, there shall be no stuffing: stuff_pending logic is removed and 0xFF passes through unmodified.

Structure
REQ-034 Package jpeg_pkg shall hold: BUF_W default, the FSM state enum (RUN/PAD/DRAIN/DONE), and the constants JPEG_STUFF_BYTE=8'h00, JPEG_MARKER_BYTE=8'hFF and MAX_CODE_BITS=16.
REQ-035 Sub-module jpeg_byte_stuffer, a single-entry output register plus stuff insertion, shall sit between the accumulator and the byte port.

Verification
REQ-036 Scenario 1: codes (0b101,3),(0b11111,5) then flush, byte_ready=1 -> byte 0xBF, flush_done pulse.
REQ-037 Scenario 2: code (0xFFFF,16) then flush -> bytes FF 00 FF 00 with JPEG_BYTE_STUFF_EN defined; FF FF without it.
REQ-038 Scenario 3: code (0b0,1) then flush -> single byte 0x7F from 1-padding; code (0b1,1) then flush -> 0xFF 0x00 (stuffed).
REQ-039 Scenario 4: byte_ready=0 while sending four (0xAAAA,16) codes -> code_ready drops once fill_count>16, byte_data stays 0xAA, and no loss once byte_ready=1.
REQ-040 Scenario 5: reset_n pulsed low after 11 bits are buffered -> no output bytes, busy=0, and the next flush gives flush_done with zero bytes.
REQ-041 Scenario 6: random code lengths 0..16 with random valid/ready versus a reference bit-queue model -> byte-exact match including stuffing.
